// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch/branch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_branch_unit_if.sv
// rtl/fetch_branch_unit_if.sv - instruction-memory request/response handshake
interface fetch_branch_unit_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_branch_unit_next_pc_calc.sv
// rtl/fetch_branch_unit_next_pc_calc.sv - next-PC selection; MISALIGN_TRAP_EN keeps raw low bits
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] imm,
    input  logic [PC_W-1:0] alu_result,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic            alu_zero,
    output logic [PC_W-1:0] target,
    output logic            misaligned_target
);
    logic [PC_W-1:0] raw_target;

    always_comb begin
        raw_target = pc + PC_W'(INST_BYTES);
        if (jalr) begin
            raw_target = alu_result & ~PC_W'(1);
        end else if (jal) begin
            raw_target = pc + imm;
        end else if (branch && alu_zero) begin
            raw_target = pc + imm;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign target = raw_target;
`else
    // Without the trap the low bits are dropped, so the target is always aligned.
    assign target = raw_target & ~PC_W'(3);
`endif

    assign misaligned_target = |target[1:0];

endmodule

// File: rtl/fetch_branch_unit.sv
// rtl/fetch_branch_unit.sv - PC owner and one-at-a-time instruction fetch FSM; MISALIGN_TRAP_EN adds HALT
module fetch_branch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic                clk,
    input  logic                reset,
    fetch_branch_unit_if.master imem,
    output logic                instr_valid,
    output logic [INST_W-1:0]   instr,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     pc_plus4,
    input  logic                instr_ready,
    input  logic                branch,
    input  logic                jal,
    input  logic                jalr,
    input  logic [PC_W-1:0]     imm,
    input  logic                alu_zero,
    input  logic [PC_W-1:0]     alu_result,
    output logic                misalign
);
    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]   target;
    logic              misaligned_tgt;

    next_pc_calc #(.PC_W(PC_W)) u_next_pc_calc (
        .pc                (pc_q),
        .imm               (imm),
        .alu_result        (alu_result),
        .branch            (branch),
        .jal               (jal),
        .jalr              (jalr),
        .alu_zero          (alu_zero),
        .target            (target),
        .misaligned_target (misaligned_tgt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (imem.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    instr_d = imem.imem_rsp_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (instr_ready) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned_tgt) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
`else
                    pc_d    = target;
                    state_d = FETCH;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs are forced low while reset is held so nothing leaks during the reset cycle.
    assign imem.imem_req_valid = (state_q == FETCH) && !reset;
    assign imem.imem_req_addr  = pc_q;
    assign instr_valid         = (state_q == EXEC) && !reset;
    assign instr               = instr_q;
    assign pc                  = pc_q;
    assign pc_plus4            = pc_q + PC_W'(INST_BYTES);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (state_q == HALT) && !reset;
`else
    assign misalign = misaligned_tgt;
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// tb/tb_fetch_branch_unit.sv - directed self-checking bench with a transaction-level model
module tb_fetch_branch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = '0;
    logic        alu_zero = 1'b0;
    logic [31:0] alu_result = '0;
    logic        misalign;

    fetch_branch_unit_if #(.PC_W(32), .INST_W(32)) imem_if ();

    fetch_branch_unit #(.PC_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_if),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_ready (instr_ready),
        .branch      (branch),
        .jal         (jal),
        .jalr        (jalr),
        .imm         (imm),
        .alu_zero    (alu_zero),
        .alu_result  (alu_result),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    logic        exp_req = 1'b0;
    logic        exp_ival = 1'b0;
    logic        exp_mis = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instr = 32'h0;

    logic        last_ival;
    logic [31:0] last_pc;
    logic [31:0] last_pcp4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_valid", 32'(imem_if.imem_req_valid), 32'(exp_req));
            if (exp_req) chk("req_addr", imem_if.imem_req_addr, exp_pc);
            chk("instr_valid", 32'(instr_valid), 32'(exp_ival));
            chk("instr", instr, exp_instr);
            chk("pc", pc, exp_pc);
            chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
            chk("misalign", 32'(misalign), 32'(exp_mis));
        end
    end

    function automatic logic [31:0] model_target(input logic [31:0] p, input logic [31:0] im,
                                                 input logic [31:0] alu, input bit br,
                                                 input bit jl, input bit jr, input bit z);
        if (jr)           return alu - (alu % 2);
        if (jl)           return p + im;
        if (br && z)      return p + im;
        return p + 32'd4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_req = 1'b0;
        exp_ival = 1'b0;
        exp_mis = 1'b0;
        step();
        reset = 1'b0;
        exp_pc = 32'h0;
        exp_instr = 32'h0;
        exp_req = 1'b1;
    endtask

    task automatic do_instr(input logic [31:0] data, input bit br, input bit jl, input bit jr,
                            input bit z, input logic [31:0] im, input logic [31:0] alu,
                            input int stall, input bit spurious);
        logic [31:0] t;
        // Control strobes during fetch stalls must have no effect.
        for (int i = 0; i < stall; i++) begin
            jalr = 1'b1;
            alu_result = 32'hDEAD_0000;
            step();
        end
        jalr = 1'b0;
        req_drive(1'b1);
        step();
        req_drive(1'b0);
        exp_req = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data = data;
        step();
        imem_if.imem_rsp_valid = 1'b0;
        exp_ival = 1'b1;
        exp_instr = data;
        last_ival = instr_valid;
        last_pc = pc;
        last_pcp4 = pc_plus4;
        if (spurious) begin
            imem_if.imem_rsp_valid = 1'b1;
            imem_if.imem_rsp_data = ~data;
            step();
            imem_if.imem_rsp_valid = 1'b0;
        end
        branch = br; jal = jl; jalr = jr; alu_zero = z; imm = im; alu_result = alu;
        instr_ready = 1'b1;
        t = model_target(exp_pc, im, alu, br, jl, jr, z);
        step();
        instr_ready = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0; alu_zero = 1'b0;
        exp_ival = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (t % 4 != 0) begin
            exp_req = 1'b0;
            exp_mis = 1'b1;
            return;
        end
`endif
        exp_pc = t - (t % 4);
        exp_req = 1'b1;
    endtask

    task automatic req_drive(input logic v);
        imem_if.imem_req_ready = v;
    endtask

    initial begin
        imem_if.imem_req_ready = 1'b0;
        imem_if.imem_rsp_valid = 1'b0;
        imem_if.imem_rsp_data = '0;
        step();
        cmp_en = 1'b1;
        step();
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_req", 32'(imem_if.imem_req_valid), 32'h0);
        reset = 1'b0;
        exp_req = 1'b1;

        do_instr(32'h00500093, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("lit_exec_cycle3_valid", 32'(last_ival), 32'h1);
        chk("lit_exec_cycle3_pc", last_pc, 32'h0);
        chk("lit_second_addr", imem_if.imem_req_addr, 32'h4);

        do_instr(32'h00C0006F, 0, 1, 0, 0, 32'h0000_000C, 32'h0, 0, 0);
        do_instr(32'hFE000CE3, 1, 0, 0, 1, 32'hFFFF_FFF8, 32'h0, 0, 0);
        chk("lit_branch_taken", imem_if.imem_req_addr, 32'h8);
        do_instr(32'h0080006F, 0, 1, 0, 0, 32'h0000_0008, 32'h0, 0, 0);
        do_instr(32'hFE000CE3, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 0, 0);
        chk("lit_branch_not_taken", imem_if.imem_req_addr, 32'h14);
        do_instr(32'h00C0006F, 0, 1, 0, 0, 32'h0000_000C, 32'h0, 0, 0);
        do_instr(32'h000080E7, 0, 0, 1, 0, 32'h0, 32'h0000_0101, 0, 0);
        chk("lit_jalr_pc_plus4", last_pcp4, 32'h24);
        chk("lit_jalr_addr", imem_if.imem_req_addr, 32'h100);
        do_instr(32'h11111111, 1, 1, 1, 1, 32'h0000_0040, 32'h0000_0200, 0, 0);
        chk("lit_priority_jalr", imem_if.imem_req_addr, 32'h200);
        do_instr(32'h22222222, 0, 0, 0, 0, 32'h0, 32'h0, 5, 1);
        chk("lit_after_stall", imem_if.imem_req_addr, 32'h204);
        chk("lit_spurious_dropped", instr, 32'h22222222);
        do_instr(32'h33333333, 0, 0, 1, 0, 32'h0, 32'hFFFF_FFFC, 0, 0);
        do_instr(32'h44444444, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        chk("lit_wrap", imem_if.imem_req_addr, 32'h0);
        do_instr(32'h0400006F, 0, 1, 0, 0, 32'h0000_0040, 32'h0, 0, 0);

        // Reset while a response is outstanding; the response must not land.
        req_drive(1'b1);
        step();
        req_drive(1'b0);
        exp_req = 1'b0;
        imem_if.imem_rsp_valid = 1'b1;
        imem_if.imem_rsp_data = 32'h12345678;
        do_reset();
        step();
        imem_if.imem_rsp_valid = 1'b0;
        chk("lit_reset_refetch_addr", imem_if.imem_req_addr, 32'h0);
        chk("lit_reset_instr_clear", instr, 32'h0);

        do_instr(32'h0060006F, 0, 1, 0, 0, 32'h0000_0006, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        repeat (4) step();
        chk("lit_halt_misalign", 32'(misalign), 32'h1);
        chk("lit_halt_no_req", 32'(imem_if.imem_req_valid), 32'h0);
        do_reset();
        step();
        chk("lit_halt_exit_req", 32'(imem_if.imem_req_valid), 32'h1);
`else
        chk("lit_misalign_forced", imem_if.imem_req_addr, 32'h4);
        chk("lit_misalign_tied0", 32'(misalign), 32'h0);
`endif
        step();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
